// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, a, b, flush, input busy, done, div_zero, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: Hi/Lo owner with 1-cycle multiply/moves and a 1-bit/cycle restoring divider.
// Define MULDIV_MADD_EN to make op 111 a signed multiply-accumulate; otherwise it is a NOP.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic     clkin,
    input logic     rst,
    muldiv_if.slave bus
);
    typedef enum logic {IDLE, DIV} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic negq_q, negq_d, negr_q, negr_d, done_q, done_d, dz_q, dz_d;
    logic accept, msgn, dsgn, qbit;
    logic [PW-1:0] ma, mb, prod;
    logic [WIDTH:0] trial, diff;
    logic [WIDTH-1:0] rem_n, quo_n, abs_a, abs_b;

    assign accept = bus.start & ~bus.flush & (state_q == IDLE);
    assign msgn   = (bus.op == 3'b001) | (bus.op == 3'b111);
    assign dsgn   = bus.op == 3'b011;
    // Extending to 2*WIDTH lets one multiplier serve signed and unsigned products.
    assign ma     = {{WIDTH{msgn & bus.a[WIDTH-1]}}, bus.a};
    assign mb     = {{WIDTH{msgn & bus.b[WIDTH-1]}}, bus.b};
    assign prod   = ma * mb;
    assign abs_a  = (dsgn & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b  = (dsgn & bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign trial  = {rem_q, quo_q[WIDTH-1]};
    assign diff   = trial - {1'b0, dvs_q};
    assign qbit   = ~diff[WIDTH];
    assign rem_n  = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_n  = {quo_q[WIDTH-2:0], qbit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        if (accept) begin
            case (bus.op)
                3'b001, 3'b010: begin
                    {hi_d, lo_d} = prod;
                    done_d       = 1'b1;
                end
                3'b011, 3'b100: begin
                    if (bus.b == '0) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        state_d = DIV;
                        cnt_d   = CW'(WIDTH);
                        rem_d   = '0;
                        quo_d   = abs_a;
                        dvs_d   = abs_b;
                        negq_d  = dsgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        negr_d  = dsgn & bus.a[WIDTH-1];
                    end
                end
                3'b101: begin
                    hi_d   = bus.a;
                    done_d = 1'b1;
                end
                3'b110: begin
                    lo_d   = bus.a;
                    done_d = 1'b1;
                end
`ifdef MULDIV_MADD_EN
                3'b111: begin
                    {hi_d, lo_d} = {hi_q, lo_q} + prod;
                    done_d       = 1'b1;
                end
`endif
                default: ;
            endcase
        end else if (state_q == DIV) begin
            if (bus.flush) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    lo_d    = negq_q ? -quo_n : quo_n;
                    hi_d    = negr_q ? -rem_n : rem_n;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy     = state_q == DIV;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table, hand-written divide/flush/reset sequences and
// randomized ops checked against an arithmetic reference model of Hi/Lo.
module tb_muldiv_unit;
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, eh, el;
        bit          ed, edz;
    } vec_t;

    logic clkin = 1'b0;
    logic rst   = 1'b0;
    int checks = 0, failures = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    vec_t tbl[10];

    muldiv_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (.clkin(clkin), .rst(rst), .bus(bus));

    always #5 clkin = ~clkin;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one op and check timing and results; m_hi/m_lo hold the prior expected Hi/Lo.
    task automatic exec(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input bit ed, input bit edz,
                        input string nm);
        bit isdiv, bad;
        isdiv = (o == 3'd3 || o == 3'd4) && y != 0;
        bad   = 1'b0;
        @(negedge clkin);
        chk({nm, " idle_done"}, {63'd0, bus.done}, 64'd0);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(negedge clkin);
        bus.start = 1'b0;
        if (isdiv) begin
            for (int c = 1; c <= 32; c++) begin
                if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) bad = 1'b1;
                @(negedge clkin);
            end
            chk({nm, " busy_window"}, {63'd0, bad}, 64'd0);
        end
        chk({nm, " flags"}, {61'd0, bus.busy, bus.done, bus.div_zero}, {61'd0, 1'b0, ed, edz});
        chk({nm, " hilo"}, {bus.hi, bus.lo}, {eh, el});
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic model_run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sa, sb;
        logic [31:0] eh, el;
        bit ed, edz;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        eh = m_hi; el = m_lo; ed = 1'b1; edz = 1'b0;
        case (o)
            3'd1: {eh, el} = sa * sb;
            3'd2: {eh, el} = {32'd0, x} * {32'd0, y};
            3'd3: if (y == 0) edz = 1'b1; else begin el = 32'(sa / sb); eh = 32'(sa % sb); end
            3'd4: if (y == 0) edz = 1'b1; else begin el = x / y; eh = x % y; end
            3'd5: eh = x;
            3'd6: el = x;
`ifdef MULDIV_MADD_EN
            3'd7: {eh, el} = {m_hi, m_lo} + 64'(sa * sb);
`else
            3'd7: ed = 1'b0;
`endif
            default: ed = 1'b0;
        endcase
        exec(o, x, y, eh, el, ed, edz, $sformatf("rand op%0d", o));
    endtask

    initial begin
        bit seen;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        tbl[0] = '{3'd2, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 1'b1, 1'b0};
        tbl[1] = '{3'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 1'b0};
        tbl[2] = '{3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0};
        tbl[3] = '{3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0};
        tbl[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b1, 1'b0};
        tbl[5] = '{3'd3, 32'd55, 32'd0, 32'd0, 32'h80000000, 1'b1, 1'b1};
        tbl[6] = '{3'd6, 32'd5, 32'd9, 32'd0, 32'd5, 1'b1, 1'b0};
        tbl[7] = '{3'd5, 32'd0, 32'd9, 32'd0, 32'd5, 1'b1, 1'b0};
`ifdef MULDIV_MADD_EN
        tbl[8] = '{3'd7, 32'd2, 32'd3, 32'd0, 32'd11, 1'b1, 1'b0};
`else
        tbl[8] = '{3'd7, 32'd2, 32'd3, 32'd0, 32'd5, 1'b0, 1'b0};
`endif
        tbl[9] = '{3'd0, 32'd1, 32'd1, 32'd0, tbl[8].el, 1'b0, 1'b0};

        repeat (2) @(negedge clkin);
        chk("reset state", {bus.hi, bus.lo}, 64'd0);
        chk("reset flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        rst = 1'b1;

        // Reset in the middle of a divide.
        exec(3'd5, 32'h12345678, 32'd0, 32'h12345678, 32'd0, 1'b1, 1'b0, "mthi pre");
        exec(3'd6, 32'h9ABCDEF0, 32'd0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, "mtlo pre");
        @(negedge clkin);
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clkin);
        bus.start = 1'b0;
        repeat (5) @(negedge clkin);
        chk("pre-reset busy", {63'd0, bus.busy}, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async reset hilo", {bus.hi, bus.lo}, 64'd0);
        chk("async reset flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        @(negedge clkin);
        rst = 1'b1;
        m_hi = '0; m_lo = '0;

        foreach (tbl[i]) exec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, tbl[i].ed, tbl[i].edz,
                              $sformatf("vec%0d", i));

        // Back-to-back single-cycle ops.
        @(negedge clkin);
        bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'hCAFE0001;
        @(negedge clkin);
        chk("b2b mtlo", {31'd0, bus.done, bus.lo}, {31'd0, 1'b1, 32'hCAFE0001});
        bus.op = 3'd5; bus.a = 32'hBEEF0002;
        @(negedge clkin);
        bus.start = 1'b0;
        chk("b2b mthi", {31'd0, bus.done, bus.hi}, {31'd0, 1'b1, 32'hBEEF0002});
        m_hi = 32'hBEEF0002; m_lo = 32'hCAFE0001;

        // Start while busy is ignored and does not queue.
        @(negedge clkin);
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'd100; bus.b = 32'd7;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clkin);
            bus.start = (c == 2);
            bus.op = 3'd1; bus.a = 32'd3; bus.b = 32'd3;
            if (c == 3) chk("busy start ignored", {31'd0, bus.done, bus.hi}, {31'd0, 1'b0, m_hi});
            if (c == 33) chk("busy div result", {30'd0, bus.busy, bus.done, bus.hi, bus.lo}, {30'd0, 2'b01, 32'd2, 32'd14});
            if (c == 34) chk("no queued op", {31'd0, bus.done, bus.hi, bus.lo}, {31'd0, 1'b0, 32'd2, 32'd14});
        end
        m_hi = 32'd2; m_lo = 32'd14;

        // Flush in cycle 10 of a divide.
        @(negedge clkin);
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd1000; bus.b = 32'd3;
        seen = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clkin);
            bus.start = 1'b0;
            bus.flush = (c == 10);
            if (bus.done) seen = 1'b1;
            if (c == 10) chk("flush busy before", {63'd0, bus.busy}, 64'd1);
            if (c == 11) chk("flush busy after", {31'd0, bus.busy, bus.hi, bus.lo}, {31'd0, 1'b0, m_hi, m_lo});
        end
        chk("flush no done", {63'd0, seen}, 64'd0);
        chk("flush hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

        // Start and flush together.
        @(negedge clkin);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd3; bus.a = 32'd77; bus.b = 32'd5;
        @(negedge clkin);
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("start+flush flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        chk("start+flush hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            int sel;
            o   = 3'($urandom_range(0, 7));
            x   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            sel = $urandom_range(0, 9);
            y   = (sel == 0) ? 32'd0 : (sel < 4) ? 32'($urandom_range(1, 20)) : (sel == 4) ? 32'hFFFFFFFF : $urandom;
            model_run(o, x, y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
